// File: rtl/aes_engine_scheduler.sv
// aes_engine_scheduler
//   Shares one AES engine pair (non-pipelined encrypt and decrypt cores on a
//   common key/data bus) between two requesters. One job at a time is accepted
//   through a round-robin valid/ready handshake. The job's operands are held on
//   the engine bus for LATENCY cycles. The selected core's result is then
//   captured and returned to the owning requester on a valid/ready response
//   channel.
//
// Parameters
//   LATENCY    cycles the engine needs stable inputs before its output is valid (1..255)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o job handshake, requester N (0/1)
//   reqN_mode_i                 0 = encrypt, 1 = decrypt
//   reqN_key_i / reqN_data_i    128-bit key and text
//   respN_valid_o / respN_ready_i response handshake, requester N
//   resp_data_o                 shared result bus, qualified by respN_valid_o
//   eng_key_o / eng_data_o      operands to both cores
//   eng_mode_o                  mode of the job in flight
//   enc_result_i / dec_result_i core outputs
//   busy_o                      high whenever the scheduler is not idle
module aes_engine_scheduler #(
  parameter int unsigned LATENCY = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic         req0_mode_i,
  input  logic [127:0] req0_key_i,
  input  logic [127:0] req0_data_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic         req1_mode_i,
  input  logic [127:0] req1_key_i,
  input  logic [127:0] req1_data_i,
  output logic         resp0_valid_o,
  input  logic         resp0_ready_i,
  output logic         resp1_valid_o,
  input  logic         resp1_ready_i,
  output logic [127:0] resp_data_o,
  output logic [127:0] eng_key_o,
  output logic [127:0] eng_data_o,
  output logic         eng_mode_o,
  input  logic [127:0] enc_result_i,
  input  logic [127:0] dec_result_i,
  output logic         busy_o
);

  localparam logic [7:0] LAT8 = 8'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [127:0] key_q;
  logic [127:0] data_q;
  logic [127:0] result_q;
  logic         mode_q;
  logic         owner_q;
  logic         last_grant;
  logic [7:0]   cnt;

  logic         grant;
  logic         accept;
  logic         cnt_last;
  logic         resp_hs;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  assign accept   = req0_ready_o | req1_ready_o;
  assign cnt_last = (cnt == 8'd1);
  assign resp_hs  = (state == RESP) && (owner_q ? resp1_ready_i : resp0_ready_i);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (cnt_last) state_nxt = RESP;
      RESP:    if (resp_hs)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready_o  = 1'b0;
    req1_ready_o  = 1'b0;
    resp0_valid_o = 1'b0;
    resp1_valid_o = 1'b0;
    busy_o        = (state != IDLE);
    if (state == IDLE) begin
      req0_ready_o = req0_valid_i && !grant;
      req1_ready_o = req1_valid_i && grant;
    end
    if (state == RESP) begin
      resp0_valid_o = !owner_q;
      resp1_valid_o = owner_q;
    end
  end

  // Job datapath: operands latched on accept drive the engine directly and
  // persist after completion; the counter holds at 1 on the capture cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        key_q      <= grant ? req1_key_i  : req0_key_i;
        data_q     <= grant ? req1_data_i : req0_data_i;
        mode_q     <= grant ? req1_mode_i : req0_mode_i;
        owner_q    <= grant;
        last_grant <= grant;
        cnt        <= LAT8;
      end else if (state == RUN) begin
        if (cnt_last) begin
          result_q <= mode_q ? dec_result_i : enc_result_i;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

  assign eng_key_o   = key_q;
  assign eng_data_o  = data_q;
  assign eng_mode_o  = mode_q;
  assign resp_data_o = result_q;

endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Directed testbench for aes_engine_scheduler with LATENCY = 11.
// The engine stub returns the FIPS-197 vector for the known key/text pairs and
// a simple xor mix otherwise. It only returns a good value once the operands
// have been stable long enough, so an early capture shows up as a wrong result.
module tb_aes_engine_scheduler;

  localparam int unsigned LAT = 11;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX_E = {4{32'h5a5a0f0f}};
  localparam logic [127:0] MIX_D = {4{32'hc3c39696}};
  localparam logic [127:0] BAD   = {4{32'hdeadbeef}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_mode = 1'b0, req1_mode = 1'b0;
  logic [127:0] req0_key = '0, req1_key = '0, req0_data = '0, req1_data = '0;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic         req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o;
  logic [127:0] resp_data_o, eng_key_o, eng_data_o;
  logic         eng_mode_o, busy_o;
  logic [127:0] enc_result, dec_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_engine_scheduler #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready_o), .req0_mode_i(req0_mode),
    .req0_key_i(req0_key), .req0_data_i(req0_data),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready_o), .req1_mode_i(req1_mode),
    .req1_key_i(req1_key), .req1_data_i(req1_data),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready),
    .resp_data_o(resp_data_o), .eng_key_o(eng_key_o), .eng_data_o(eng_data_o),
    .eng_mode_o(eng_mode_o), .enc_result_i(enc_result), .dec_result_i(dec_result),
    .busy_o(busy_o)
  );

  // Engine stub
  function automatic logic [127:0] enc_model(input logic [127:0] k, input logic [127:0] d);
    if (k == K && d == P) return C;
    return k ^ d ^ MIX_E;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] k, input logic [127:0] d);
    if (k == K && d == C) return P;
    return k ^ d ^ MIX_D;
  endfunction

  logic [127:0] sk = '0, sd = '0;
  logic         sm = 1'b0;
  int           age = 0;

  always @(posedge clk) begin
    if (eng_key_o !== sk || eng_data_o !== sd || eng_mode_o !== sm) begin
      sk  <= eng_key_o;
      sd  <= eng_data_o;
      sm  <= eng_mode_o;
      age <= 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  // In cycle k after an operand change, age == k-1; good output only from cycle LAT.
  wire stable = (eng_key_o === sk) && (eng_data_o === sd) && (eng_mode_o === sm) && (age >= int'(LAT) - 1);
  assign enc_result = stable ? enc_model(eng_key_o, eng_data_o) : BAD;
  assign dec_result = stable ? dec_model(eng_key_o, eng_data_o) : BAD;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit who, input logic v, input logic m,
                       input logic [127:0] k, input logic [127:0] d);
    if (!who) begin
      req0_valid = v; req0_mode = m; req0_key = k; req0_data = d;
    end else begin
      req1_valid = v; req1_mode = m; req1_key = k; req1_data = d;
    end
  endtask

  function automatic logic rvalid(input bit who);
    return who ? resp1_valid_o : resp0_valid_o;
  endfunction

  function automatic logic qready(input bit who);
    return who ? req1_ready_o : req0_ready_o;
  endfunction

  // One job from requester `who`, responses always taken.
  task automatic single(input string tag, input bit who, input logic m,
                        input logic [127:0] k, input logic [127:0] d, input logic [127:0] exp);
    int  n;
    bit  other_seen;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drive(who, 1'b1, m, k, d);
    #1;
    check({tag, "_rdy_own"}, qready(who), 1'b1);
    check({tag, "_rdy_oth"}, qready(!who), 1'b0);
    step();
    drive(who, 1'b0, m, k, d);
    check({tag, "_eng_key"}, eng_key_o, k);
    check({tag, "_eng_data"}, eng_data_o, d);
    check({tag, "_eng_mode"}, eng_mode_o, m);
    check({tag, "_busy"}, busy_o, 1'b1);
    n = 1;
    other_seen = 1'b0;
    while (!rvalid(who) && n < 40) begin
      if (rvalid(!who)) other_seen = 1'b1;
      step();
      n++;
    end
    check({tag, "_resp_cycle"}, n, LAT + 1);
    check({tag, "_resp_data"}, resp_data_o, exp);
    check({tag, "_other_resp"}, other_seen | rvalid(!who), 1'b0);
    step();
    check({tag, "_idle_busy"}, busy_o, 1'b0);
    check({tag, "_idle_rvalid"}, rvalid(who), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    logic [127:0] k2, d2;
    int acc_cyc[4];
    int acc_own[4];
    int n_acc;

    // Reset state
    step(); step();
    check("rst_busy", busy_o, 1'b0);
    check("rst_eng_key", eng_key_o, '0);
    check("rst_resp_data", resp_data_o, '0);
    check("rst_rvalid", {resp0_valid_o, resp1_valid_o}, 2'b00);
    rst = 1'b0;
    step();

    single("enc", 1'b0, 1'b0, K, P, C);
    single("dec", 1'b1, 1'b1, K, C, P);

    // Response backpressure, then a job whose inputs churn during RUN
    resp0_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, K, P);
    #1;
    check("bp_rdy", req0_ready_o, 1'b1);
    step();
    req0_valid = 1'b0;
    n = 1;
    while (!resp0_valid_o && n < 40) begin step(); n++; end
    check("bp_resp_cycle", n, LAT + 1);
    k2 = 128'hfedcba98765432100123456789abcdef;
    d2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    drive(1'b0, 1'b1, 1'b0, k2, d2);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", resp0_valid_o, 1'b1);
      check("bp_data", resp_data_o, C);
      check("bp_busy", busy_o, 1'b1);
      check("bp_no_accept", req0_ready_o, 1'b0);
      step();
    end
    resp0_ready = 1'b1;
    #1;
    check("bp_valid_last", resp0_valid_o, 1'b1);
    step();
    check("bp_idle_busy", busy_o, 1'b0);
    check("bp_idle_rdy", req0_ready_o, 1'b1);
    step();
    req0_valid = 1'b0;
    n = 1;
    while (!resp0_valid_o && n < 40) begin
      check("churn_key", eng_key_o, k2);
      check("churn_data", eng_data_o, d2);
      req0_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
      req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      n++;
    end
    check("churn_resp_cycle", n, LAT + 1);
    check("churn_result", resp_data_o, k2 ^ d2 ^ MIX_E);
    step();
    check("churn_idle", busy_o, 1'b0);

    // Reset in cycle 5 of a job
    drive(1'b1, 1'b1, 1'b1, K, C);
    step();
    req1_valid = 1'b0;
    for (int i = 1; i < 5; i++) step();
    check("mid_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", {req0_ready_o, req1_ready_o}, 2'b00);
    check("mid_rst_rvalid", {resp0_valid_o, resp1_valid_o}, 2'b00);
    check("mid_rst_resp_data", resp_data_o, '0);
    check("mid_rst_eng_key", eng_key_o, '0);
    check("mid_rst_eng_data", eng_data_o, '0);
    check("mid_rst_eng_mode", eng_mode_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (resp0_valid_o || resp1_valid_o || busy_o) seen = 1'b1;
      step();
    end
    check("mid_rst_no_resp", seen, 1'b0);

    // Tie after reset: accepts 0,1,0,1 at cycles 0,13,26,39
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, K, P);
    drive(1'b1, 1'b1, 1'b1, K, C);
    #1;
    n_acc = 0;
    for (int c = 0; c < 52; c++) begin
      if (req0_ready_o && req1_ready_o) check("tie_both_rdy", 2'b11, 2'b01);
      if ((req0_ready_o || req1_ready_o) && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        acc_own[n_acc] = req1_ready_o ? 1 : 0;
        n_acc++;
      end
      if (resp0_valid_o) check("tie_resp0_data", resp_data_o, C);
      if (resp1_valid_o) check("tie_resp1_data", resp_data_o, P);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_n_acc", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_acc) begin
        check($sformatf("tie_acc%0d_cycle", i), acc_cyc[i], i * (LAT + 2));
        check($sformatf("tie_acc%0d_owner", i), acc_own[i], i % 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
